reg_file_2r1w: RTL and testbench

- Register file directly upstream of the datapath ALU.
- Supplies the ALU's A operand (port P) and B operand (port Q) from a bank of general-purpose registers.
- Accepts the ALU/memory result back through a single write port.
- Reads are registered (1-cycle latency) with write-to-read bypass, so a register written in cycle N is returned correctly by a read issued in cycle N.

---
 rtl/processor_pkg.sv | 33 +++
 rtl/reg_file_2r1w_read_port.sv | 56 +++++
 rtl/reg_file_2r1w.sv | 81 ++++++++
 tb/tb_reg_file_2r1w.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: datapath widths, register-file sizing and the
// ALU select encoding, so that control decode lives in exactly one place.
package processor_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int N_REGS         = 16;
  localparam int REG_ADDR_WIDTH = $clog2(N_REGS);

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  // ALU operation select, decoded identically by the ALU and by control.
  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_AND  = 2'd3
  } alu_sel_e;

  // Reference behaviour of the ALU for a given select; arithmetic wraps.
  function automatic data_t alu_eval(input alu_sel_e sel, input data_t a, input data_t b);
    data_t res;
    case (sel)
      ALU_PASS: res = a;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      default:  res = {DATA_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// One registered read port of the register file: range check, storage mux,
// write-to-read bypass and the output register. Instantiated once per port.
module rf_read_port #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REGS     = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         w_en,
  input  logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [N_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic                  rd_in_range_s;
  logic                  w_in_range_s;
  logic                  bypass_s;
  logic [DATA_WIDTH-1:0] stored_s;
  logic [DATA_WIDTH-1:0] next_data_s;
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Select the addressed register (0 when out of range) and apply the bypass.
  always_comb begin
    rd_in_range_s = (32'(rd_addr) < N_REGS);
    w_in_range_s  = (32'(w_addr) < N_REGS);
    bypass_s      = w_en && (w_addr == rd_addr) && w_in_range_s;
    stored_s      = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < N_REGS; i++) begin
      stored_s = (rd_in_range_s && (rd_addr == ADDR_WIDTH'(i)))
               ? regs_flat[i*DATA_WIDTH +: DATA_WIDTH] : stored_s;
    end
    if (bypass_s) begin
      next_data_s = w_data;
    end else begin
      next_data_s = stored_s;
    end
  end

  // Output register: loads only on an enabled read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= next_data_s;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file feeding the ALU operands. Owns the
// storage array and write logic; each read port is a registered rf_read_port.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = processor_pkg::DATA_WIDTH,
  parameter int N_REGS     = processor_pkg::N_REGS,
  localparam int ADDR_WIDTH = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  W_en,
  input  logic [ADDR_WIDTH-1:0] W_addr,
  input  logic [DATA_WIDTH-1:0] W_data,
  input  logic                  Rp_en,
  input  logic [ADDR_WIDTH-1:0] Rp_addr,
  input  logic                  Rq_en,
  input  logic [ADDR_WIDTH-1:0] Rq_addr,
  output logic [DATA_WIDTH-1:0] Rp_data,
  output logic [DATA_WIDTH-1:0] Rq_data
);

  logic [DATA_WIDTH-1:0]        regs_r [N_REGS];
  logic [N_REGS*DATA_WIDTH-1:0] regs_flat_s;
  logic                         w_in_range_s;

  // Writes to indices beyond the populated range are dropped.
  always_comb begin
    w_in_range_s = (32'(W_addr) < N_REGS);
  end

  // Storage array: cleared on reset, one register updated per enabled write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (W_en && w_in_range_s && (W_addr == ADDR_WIDTH'(i))) begin
          regs_r[i] <= W_data;
        end
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign regs_flat_s[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_REGS     (N_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_p (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .rd_en     (Rp_en),
    .rd_addr   (Rp_addr),
    .w_en      (W_en),
    .w_addr    (W_addr),
    .w_data    (W_data),
    .regs_flat (regs_flat_s),
    .rd_data   (Rp_data)
  );

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_REGS     (N_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_q (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .rd_en     (Rq_en),
    .rd_addr   (Rq_addr),
    .w_en      (W_en),
    .w_addr    (W_addr),
    .w_data    (W_data),
    .regs_flat (regs_flat_s),
    .rd_data   (Rq_data)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a 16-entry instance and a 12-entry instance share
// one stimulus stream; a reference model per instance feeds expected-value
// queues that each test pops and compares after the read edge.
module tb_reg_file_2r1w;
  import processor_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        W_en;
  logic [3:0]  W_addr;
  logic [15:0] W_data;
  logic        Rp_en;
  logic [3:0]  Rp_addr;
  logic        Rq_en;
  logic [3:0]  Rq_addr;
  logic [15:0] Rp_data, Rq_data, Rp_data12, Rq_data12;

  int tests = 0;
  int fails = 0;

  logic [15:0] mdl   [16];
  logic [15:0] mdl12 [16];
  logic [15:0] last_p, last_q, last_p12, last_q12;
  logic [15:0] q_p[$], q_q[$], q_p12[$], q_q12[$];
  logic [15:0] exp_v;

  always #5 Clk = ~Clk;

  reg_file_2r1w dut (
    .Clk(Clk), .Reset_n(Reset_n), .W_en(W_en), .W_addr(W_addr), .W_data(W_data),
    .Rp_en(Rp_en), .Rp_addr(Rp_addr), .Rq_en(Rq_en), .Rq_addr(Rq_addr),
    .Rp_data(Rp_data), .Rq_data(Rq_data)
  );

  reg_file_2r1w #(.DATA_WIDTH(16), .N_REGS(12)) dut12 (
    .Clk(Clk), .Reset_n(Reset_n), .W_en(W_en), .W_addr(W_addr), .W_data(W_data),
    .Rp_en(Rp_en), .Rp_addr(Rp_addr), .Rq_en(Rq_en), .Rq_addr(Rq_addr),
    .Rp_data(Rp_data12), .Rq_data(Rq_data12)
  );

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = 16'h0000;
      mdl12[i] = 16'h0000;
    end
    last_p = 16'h0000; last_q = 16'h0000; last_p12 = 16'h0000; last_q12 = 16'h0000;
  endtask

  // One clock of stimulus; target 1 queues expectations for the 16-entry
  // instance, target 2 for the 12-entry instance, 0 queues nothing.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic pe, input logic [3:0] pa,
                       input logic qe, input logic [3:0] qa, input int target);
    @(negedge Clk);
    W_en = we; W_addr = wa; W_data = wd;
    Rp_en = pe; Rp_addr = pa; Rq_en = qe; Rq_addr = qa;
    if (pe) begin
      last_p   = (we && wa == pa) ? wd : mdl[pa];
      last_p12 = (we && wa == pa && wa < 4'd12) ? wd : ((pa < 4'd12) ? mdl12[pa] : 16'h0000);
    end
    if (qe) begin
      last_q   = (we && wa == qa) ? wd : mdl[qa];
      last_q12 = (we && wa == qa && wa < 4'd12) ? wd : ((qa < 4'd12) ? mdl12[qa] : 16'h0000);
    end
    if (we) begin
      mdl[wa] = wd;
      if (wa < 4'd12) mdl12[wa] = wd;
    end
    if (target == 1) begin q_p.push_back(last_p); q_q.push_back(last_q); end
    if (target == 2) begin q_p12.push_back(last_p12); q_q12.push_back(last_q12); end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (Rp_data !== 16'h0000 || Rq_data !== 16'h0000) begin
      fails++;
      $display("FAIL reset_out: P=%h Q=%h expected 0000", Rp_data, Rq_data);
    end
    tests++;
    if (Rp_data12 !== 16'h0000 || Rq_data12 !== 16'h0000) begin
      fails++;
      $display("FAIL reset_out12: P=%h Q=%h expected 0000", Rp_data12, Rq_data12);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd3, 1);
    exp_v = q_p.pop_front();
    tests++;
    if (Rp_data !== exp_v || Rp_data !== 16'h1234) begin
      fails++; $display("FAIL write_read_p: got %h expected %h", Rp_data, exp_v);
    end
    exp_v = q_q.pop_front();
    tests++;
    if (Rq_data !== exp_v || Rq_data !== 16'h1234) begin
      fails++; $display("FAIL write_read_q: got %h expected %h", Rq_data, exp_v);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd5, 16'h0001, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 1'b1, 4'd6, 1);
    exp_v = q_p.pop_front();
    tests++;
    if (Rp_data !== exp_v) begin
      fails++; $display("FAIL bypass_p: got %h expected %h", Rp_data, exp_v);
    end
    exp_v = q_q.pop_front();
    tests++;
    if (Rq_data !== exp_v) begin
      fails++; $display("FAIL other_addr_q: got %h expected %h", Rq_data, exp_v);
    end
    // both ports bypass on the same write
    drive(1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 1'b1, 4'd9, 1);
    exp_v = q_p.pop_front();
    tests++;
    if (Rp_data !== exp_v) begin
      fails++; $display("FAIL dual_bypass_p: got %h expected %h", Rp_data, exp_v);
    end
    exp_v = q_q.pop_front();
    tests++;
    if (Rq_data !== exp_v) begin
      fails++; $display("FAIL dual_bypass_q: got %h expected %h", Rq_data, exp_v);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd2, 16'h00AA, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd2, 16'h5555, 1'b0, 4'd7, 1'b0, 4'd0, 1);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 1'b0, 4'd0, 1);
    for (int k = 0; k < 2; k++) begin
      exp_v = q_p.pop_front();
      tests++;
      if (Rp_data !== exp_v || exp_v !== 16'h00AA) begin
        fails++; $display("FAIL hold_p[%0d]: got %h expected %h", k, Rp_data, exp_v);
      end
      void'(q_q.pop_front());
    end
  endtask

  task automatic test_alu_operands();
    drive(1'b1, 4'd1, 16'd40000, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd2, 16'd30000, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 1'b1, 4'd2, 1);
    exp_v = q_p.pop_front();
    tests++;
    if (Rp_data !== exp_v) begin
      fails++; $display("FAIL alu_a: got %h expected %h", Rp_data, exp_v);
    end
    exp_v = q_q.pop_front();
    tests++;
    if (Rq_data !== exp_v) begin
      fails++; $display("FAIL alu_b: got %h expected %h", Rq_data, exp_v);
    end
    tests++;
    if (alu_eval(ALU_ADD, Rp_data, Rq_data) !== 16'd4464) begin
      fails++; $display("FAIL alu_add: got %0d expected 4464", alu_eval(ALU_ADD, Rp_data, Rq_data));
    end
    tests++;
    if (alu_eval(ALU_SUB, Rp_data, Rq_data) !== 16'd10000) begin
      fails++; $display("FAIL alu_sub: got %0d expected 10000", alu_eval(ALU_SUB, Rp_data, Rq_data));
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'(a), 16'(a) * 16'h0101, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(a), 1'b1, 4'(15 - a), 1);
      exp_v = q_p.pop_front();
      tests++;
      if (Rp_data !== exp_v || Rp_data !== 16'(a) * 16'h0101) begin
        fails++; $display("FAIL sweep_p[%0d]: got %h expected %h", a, Rp_data, exp_v);
      end
      exp_v = q_q.pop_front();
      tests++;
      if (Rq_data !== exp_v) begin
        fails++; $display("FAIL sweep_q[%0d]: got %h expected %h", 15 - a, Rq_data, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd6, 0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (Rp_data !== 16'h0000 || Rq_data !== 16'h0000) begin
      fails++; $display("FAIL async_reset: P=%h Q=%h expected 0000", Rp_data, Rq_data);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(a), 1'b1, 4'(a), 1);
      exp_v = q_p.pop_front();
      tests++;
      if (Rp_data !== exp_v || Rp_data !== 16'h0000) begin
        fails++; $display("FAIL post_reset_p[%0d]: got %h expected %h", a, Rp_data, exp_v);
      end
      exp_v = q_q.pop_front();
      tests++;
      if (Rq_data !== exp_v) begin
        fails++; $display("FAIL post_reset_q[%0d]: got %h expected %h", a, Rq_data, exp_v);
      end
    end
  endtask

  task automatic test_n12();
    for (int a = 0; a < 12; a++) begin
      drive(1'b1, 4'(a), 16'hA000 | 16'(a), 1'b0, 4'd0, 1'b0, 4'd0, 0);
    end
    drive(1'b1, 4'd13, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd12, 16'hEEEE, 1'b0, 4'd0, 1'b0, 4'd0, 0);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(a), 1'b1, 4'(a), 2);
      exp_v = q_p12.pop_front();
      tests++;
      if (Rp_data12 !== exp_v) begin
        fails++; $display("FAIL n12_p[%0d]: got %h expected %h", a, Rp_data12, exp_v);
      end
      exp_v = q_q12.pop_front();
      tests++;
      if (Rq_data12 !== exp_v) begin
        fails++; $display("FAIL n12_q[%0d]: got %h expected %h", a, Rq_data12, exp_v);
      end
    end
    // out-of-range write must not bypass into a read of the same index
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b0, 4'd0, 0);
    drive(1'b1, 4'd13, 16'h1357, 1'b1, 4'd13, 1'b1, 4'd0, 2);
    exp_v = q_p12.pop_front();
    tests++;
    if (Rp_data12 !== exp_v || Rp_data12 !== 16'h0000) begin
      fails++; $display("FAIL n12_oob_bypass: got %h expected %h", Rp_data12, exp_v);
    end
    exp_v = q_q12.pop_front();
    tests++;
    if (Rq_data12 !== exp_v) begin
      fails++; $display("FAIL n12_q0: got %h expected %h", Rq_data12, exp_v);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    W_en = 1'b0; W_addr = 4'd0; W_data = 16'h0000;
    Rp_en = 1'b0; Rp_addr = 4'd0; Rq_en = 1'b0; Rq_addr = 4'd0;
    model_reset();
    #1;
    test_reset();
    @(posedge Clk);
    #1;
    test_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    test_write_read();
    test_bypass();
    test_hold();
    test_alu_operands();
    test_sweep();
    test_async_reset();
    test_n12();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
